// File: rtl/trig_capture.sv
// trig_capture: triggered waveform capture buffer.
//   Arms on a single-cycle pulse, keeps PRE_TRIG samples ahead of the
//   trigger, then waits for a signed level crossing.  After the crossing it
//   fills the rest of the DEPTH-sample circular buffer and holds it for
//   display readout.
// Parameters: DEPTH (power of two), PRE_TRIG (1..DEPTH-2), AUTO_TIMEOUT.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   sample_in/valid       12-bit signed waveform sample and its qualifier
//   trig_level/trig_edge  signed threshold, 0 = rising, 1 = falling
//   arm                   pulse that starts or restarts a capture
//   rd_addr/rd_data       read index (0 = oldest sample), registered data
//   busy/done/trig_auto   capture status
// Build option: define AUTO_TRIG_EN to force a trigger after AUTO_TIMEOUT
//   accepted samples in WAIT_TRIG; otherwise trig_auto is tied 0.
module trig_capture #(
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned PRE_TRIG     = 64,
   parameter int unsigned AUTO_TIMEOUT = 65535,
   localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic signed [11:0]  sample_in,
   input  logic                sample_valid,
   input  logic signed [11:0]  trig_level,
   input  logic                trig_edge,
   input  logic                arm,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic signed [11:0]  rd_data,
   output logic                busy,
   output logic                done,
   output logic                trig_auto
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_WAIT_TRIG,
      S_POST,
      S_DONE
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   start_ptr;
   logic [ADDR_W-1:0]   cnt;
   logic signed [11:0]  prev;
   logic                prev_valid;
   logic                accept;
   logic                level_hit;
   logic                auto_hit;
   logic [ADDR_W-1:0]   rd_idx;

   logic signed [11:0]  mem [DEPTH];

   // arm takes priority: the sample offered alongside it is dropped
   assign accept = sample_valid && !arm &&
                   (state == S_PRE || state == S_WAIT_TRIG || state == S_POST);

   assign level_hit = prev_valid &&
                      (trig_edge ? (prev > trig_level && sample_in <= trig_level)
                                 : (prev < trig_level && sample_in >= trig_level));

   // read index wraps naturally in ADDR_W bits
   assign rd_idx = start_ptr + rd_addr;

`ifdef AUTO_TRIG_EN
   localparam int unsigned TO_W = $clog2(AUTO_TIMEOUT + 1);
   logic [TO_W-1:0] tcnt;
   assign auto_hit = (tcnt == TO_W'(AUTO_TIMEOUT - 1));
`else
   assign auto_hit  = 1'b0;
   assign trig_auto = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         start_ptr  <= '0;
         cnt        <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef AUTO_TRIG_EN
         tcnt       <= '0;
         trig_auto  <= 1'b0;
`endif
      end else if (arm) begin
         state      <= S_PRE;
         wr_ptr     <= '0;
         cnt        <= '0;
         prev_valid <= 1'b0;
         busy       <= 1'b1;
         done       <= 1'b0;
`ifdef AUTO_TRIG_EN
         tcnt       <= '0;
         trig_auto  <= 1'b0;
`endif
      end else if (accept) begin
         wr_ptr     <= wr_ptr + 1'b1;
         prev       <= sample_in;
         prev_valid <= 1'b1;
         case (state)
            S_PRE: begin
               if (cnt == ADDR_W'(PRE_TRIG - 1)) begin
                  state <= S_WAIT_TRIG;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WAIT_TRIG: begin
               if (level_hit || auto_hit) begin
                  // trigger sample lands at wr_ptr; buffer starts PRE_TRIG earlier
                  start_ptr <= wr_ptr - ADDR_W'(PRE_TRIG);
                  state     <= S_POST;
                  cnt       <= '0;
`ifdef AUTO_TRIG_EN
                  trig_auto <= !level_hit;
`endif
               end
`ifdef AUTO_TRIG_EN
               else begin
                  tcnt <= tcnt + 1'b1;
               end
`endif
            end
            S_POST: begin
               if (cnt == ADDR_W'(DEPTH - PRE_TRIG - 2)) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr] <= sample_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_data <= '0;
      else
         rd_data <= mem[rd_idx];
   end

endmodule
